// File: rtl/pmod_spi_rx.sv
// pmod_spi_rx: SPI mode 0 peripheral-side receiver, MSB first, oversampled on clk.
// csn/mosi/sck are synchronised, sck rising edges are detected in the clk domain,
// and each completed WIDTH-bit word is offered on a valid/ready output register.
//
// Ports:
//   clk        system clock (100 MHz)
//   rstn       synchronous active-low reset
//   csn        SPI chip select, active low, asynchronous
//   mosi       SPI serial data, asynchronous
//   sck        SPI serial clock, asynchronous, <= clk/8
//   data       received word, stable while data_valid=1
//   data_valid word available
//   data_ready consumer accepts (transfer on data_valid & data_ready)
//   overrun    sticky: a completed word was dropped (cleared only by rstn)
//   busy       a partial word is being shifted
//
// Optional feature: define PMOD_SPI_RX_IDLE_RESYNC_EN to build an sck-inactivity
// counter that drops a partial word after IDLE_CYCLES clk cycles with no sck edge.
module pmod_spi_rx #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned IDLE_CYCLES = 2048
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             csn,
  input  logic             mosi,
  input  logic             sck,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  if (SYNC_STAGES < 2 || IDLE_CYCLES < 1 || WIDTH < 2) begin : g_param_check
    $error("pmod_spi_rx: needs SYNC_STAGES >= 2, IDLE_CYCLES >= 1, WIDTH >= 2");
  end

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  logic [SYNC_STAGES-1:0] csn_sync_q, mosi_sync_q, sck_sync_q;
  logic                   csn_s, mosi_s, sck_s, sck_d_q, rise;
  state_e                 state_q, state_d;
  logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]       shift_q, shift_d, word;
  logic                   word_done;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   valid_q, valid_d, overrun_q, overrun_d;

  // Synchronisers reset to the idle bus state: deselected, sck low.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      csn_sync_q  <= '1;
      mosi_sync_q <= '0;
      sck_sync_q  <= '0;
      sck_d_q     <= 1'b0;
    end else begin
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      sck_d_q     <= sck_s;
    end
  end

  assign csn_s  = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign rise   = sck_s & ~sck_d_q;
  assign word   = {shift_q[WIDTH-2:0], mosi_s};

`ifdef PMOD_SPI_RX_IDLE_RESYNC_EN
  localparam int unsigned IdleW = $clog2(IDLE_CYCLES + 1);

  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic             sck_edge, idle_hit;

  assign sck_edge = sck_s ^ sck_d_q;
  assign idle_hit = (idle_cnt_q == IdleW'(IDLE_CYCLES));

  // Saturates at IDLE_CYCLES; any sck edge or leaving SHIFT restarts it.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (state_q != StShift || state_d != StShift || sck_edge) begin
      idle_cnt_d = '0;
    end else if (!idle_hit) begin
      idle_cnt_d = idle_cnt_q + IdleW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) idle_cnt_q <= '0;
    else       idle_cnt_q <= idle_cnt_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!csn_s) begin
          state_d   = StShift;
          bit_cnt_d = '0;
        end
      end
      StShift: begin
        // Deselect wins over a coincident sck rise.
        if (csn_s) begin
          state_d   = StIdle;
          bit_cnt_d = '0;
        end else if (rise) begin
          shift_d = word;
          if (bit_cnt_q == CntW'(WIDTH - 1)) begin
            bit_cnt_d = '0;
            word_done = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
`ifdef PMOD_SPI_RX_IDLE_RESYNC_EN
        else if (idle_hit) begin
          bit_cnt_d = '0;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Output holding register; a load in the same cycle as an accept is not an overrun.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (valid_q && data_ready) valid_d = 1'b0;
    if (word_done) begin
      if (!valid_q || data_ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign overrun    = overrun_q;
  assign busy       = (bit_cnt_q != '0);

endmodule

// File: tb/tb_pmod_spi_rx.sv
// Bench for pmod_spi_rx: directed scenarios plus randomized framing. A bit-level
// model collects bits seen while csn is low and pushes each completed 32-bit word
// (with the cycle of its final sck rise) to a queue; a negedge monitor pops and
// checks data and latency each time the DUT presents a new word.
module tb_pmod_spi_rx;

  localparam int W    = 32;
  localparam int IDLE = 2048;

  typedef struct {
    logic [W-1:0] w;
    int           rc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rstn, csn, mosi, sck, data_ready;
  logic [W-1:0] data;
  logic         data_valid, overrun, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t         exp_q[$];
  logic [W-1:0] m_bits;
  int           m_cnt;
  bit           m_hold, m_pending, m_ovr;
  bit           presented, prev_acc, rand_ready;

  pmod_spi_rx #(
    .WIDTH      (W),
    .SYNC_STAGES(2),
    .IDLE_CYCLES(IDLE)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .csn       (csn),
    .mosi      (mosi),
    .sck       (sck),
    .data      (data),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one sampled bit at an sck rise while selected.
  task automatic model_rise(input logic b);
    exp_t e;
    if (csn) return;
    m_bits = {m_bits[W-2:0], b};
    m_cnt++;
    if (m_cnt == W) begin
      m_cnt = 0;
      e.w   = m_bits;
      e.rc  = cyc;
      if (m_hold && m_pending) m_ovr = 1'b1;
      else begin
        if (m_hold) m_pending = 1'b1;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic sck_bit(input logic b, input int half);
    @(posedge clk); #1 mosi = b;
    repeat (half - 1) @(posedge clk);
    #1 sck = 1'b1;
    model_rise(b);
    repeat (half) @(posedge clk);
    #1 sck = 1'b0;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int n, input int half);
    for (int i = n - 1; i >= 0; i--) sck_bit(w[i], half);
  endtask

  task automatic set_csn(input logic v);
    @(posedge clk); #1 csn = v;
    if (v) m_cnt = 0;
  endtask

  task automatic idle_clk(input int n);
    repeat (n) @(posedge clk);
`ifdef PMOD_SPI_RX_IDLE_RESYNC_EN
    if (!csn && n > IDLE + 4) m_cnt = 0;
`endif
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1 rstn = 1'b0;
    m_cnt = 0; m_ovr = 1'b0; m_pending = 1'b0;
    repeat (n) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    @(negedge clk);
    check({name, "_busy"}, busy, (m_cnt != 0));
  endtask

  // Monitor: pops one expected word per presentation.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      presented = 1'b0;
      prev_acc  = 1'b0;
    end else begin
      if (prev_acc) check("valid_one_cycle", data_valid, 1'b0);
      if (data_valid && !presented) begin
        presented = 1'b1;
        if (exp_q.size() == 0) check("unexpected_word", data, 'x);
        else begin
          e = exp_q.pop_front();
          check("word", data, e.w);
          check("latency", cyc - e.rc, 3);
        end
      end
      prev_acc = data_valid && data_ready;
      if (prev_acc) presented = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (rand_ready) #1 data_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;
    int           half;
    rstn = 1'b0; csn = 1'b1; mosi = 1'b0; sck = 1'b0; data_ready = 1'b1;
    m_bits = '0; m_cnt = 0; m_hold = 1'b0; m_pending = 1'b0; m_ovr = 1'b0;
    rand_ready = 1'b0;

    // 1: reset state, then sck activity while deselected.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_data", data, '0);
    check("rst_valid", data_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk); #1 rstn = 1'b1;
    send_bits(32'hFFFF_0000, 32, 4);
    idle_clk(10);
    drain("t1");

    // 2: single word at 200 kHz.
    set_csn(1'b0);
    send_bits(32'hDEAD_BEEF, 32, 250);
    drain("t2");
    set_csn(1'b1);
    idle_clk(10);

    // 3: two streamed words with the consumer stalled.
    data_ready = 1'b0; m_hold = 1'b1;
    set_csn(1'b0);
    send_bits(32'h1234_5678, 32, 6);
    send_bits(32'h9ABC_DEF0, 32, 6);
    idle_clk(8);
    @(negedge clk);
    check("t3_data_held", data, 32'h1234_5678);
    check("t3_valid_held", data_valid, 1'b1);
    check("t3_overrun", overrun, m_ovr);
    @(posedge clk); #1 data_ready = 1'b1;
    m_hold = 1'b0; m_pending = 1'b0;
    repeat (2) @(negedge clk);
    check("t3_valid_fall", data_valid, 1'b0);
    check("t3_overrun_sticky", overrun, m_ovr);
    set_csn(1'b1);
    drain("t3");

    // 4: partial word aborted by csn.
    set_csn(1'b0);
    send_bits(32'h0000_02C7, 10, 5);
    set_csn(1'b1);
    idle_clk(20);
    set_csn(1'b0);
    send_bits(32'hA5A5_A5A5, 32, 5);
    drain("t4");
    set_csn(1'b1);
    idle_clk(10);

    // 5: reset mid-word.
    set_csn(1'b0);
    send_bits(32'h0001_5A5A, 17, 5);
    do_reset(1);
    send_bits(32'h00FF_00FF, 32, 5);
    drain("t5");
    check("t5_overrun", overrun, m_ovr);
    set_csn(1'b1);
    idle_clk(10);

    // 6: csn held low across a long sck gap.
    set_csn(1'b0);
    send_bits(32'h0000_0016, 5, 5);
    idle_clk(3000);
    send_bits(32'h0F0F_0F0F, 32, 5);
    drain("t6");
    set_csn(1'b1);
    idle_clk(10);

    // Randomized framing, rates and consumer back-pressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      half = $urandom_range(4, 12);
      set_csn(1'b0);
      if ($urandom_range(0, 3) == 0) begin
        w = $urandom;
        send_bits(w, $urandom_range(1, W - 1), half);
        set_csn(1'b1);
        idle_clk($urandom_range(4, 15));
        set_csn(1'b0);
      end
      w = $urandom;
      send_bits(w, W, half);
      if ($urandom_range(0, 1) == 0) begin
        set_csn(1'b1);
        idle_clk($urandom_range(4, 15));
      end
    end
    set_csn(1'b1);
    drain("rand");
    rand_ready = 1'b0;
    @(posedge clk); #1 data_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rand_overrun", overrun, m_ovr);
    check("final_valid", data_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
